// File: rtl/multi_nch_disp_if.sv
// multi_nch_disp_if: groups the channel-source and display-output signals of
// multi_nch_disp into one bundle.
//   master : driven by the data sources / control (mode, sel, freeze, load,
//            data_in, point_in, les_in); observes the display outputs.
//   slave  : the multiplexer itself; drives disp_num, point_out, le_out,
//            ch_out and ch_tick.
interface multi_nch_disp_if #(
  parameter int CH = 8,
  parameter int DW = 32,
  parameter int PW = DW / 4,
  parameter int SW = $clog2(CH)
);
  logic               mode;
  logic [SW-1:0]      sel;
  logic               freeze;
  logic [CH-1:0]      load;
  logic [CH*DW-1:0]   data_in;
  logic [CH*PW-1:0]   point_in;
  logic [CH*PW-1:0]   les_in;
  logic [DW-1:0]      disp_num;
  logic [PW-1:0]      point_out;
  logic [PW-1:0]      le_out;
  logic [SW-1:0]      ch_out;
  logic               ch_tick;

  modport master (
    output mode, sel, freeze, load, data_in, point_in, les_in,
    input  disp_num, point_out, le_out, ch_out, ch_tick
  );

  modport slave (
    input  mode, sel, freeze, load, data_in, point_in, les_in,
    output disp_num, point_out, le_out, ch_out, ch_tick
  );
endinterface

// File: rtl/multi_nch_disp.sv
// multi_nch_disp: N-channel display-source multiplexer.
// Each channel has shadow registers (data, points, blink enables) loaded by
// its own strobe. The selected channel is chosen manually (sel) or by an
// auto-scan that dwells SCAN_DIV unfrozen cycles per channel. All outputs are
// registered and always update together with ch_out.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - multi_nch_disp_if.slave (controls, channel inputs, display outputs)
module multi_nch_disp #(
  parameter int CH       = 8,
  parameter int DW       = 32,
  parameter int PW       = DW / 4,
  parameter int SCAN_DIV = 50_000_000,
  localparam int SW      = $clog2(CH)
) (
  input  logic             clk,
  input  logic             rst,
  multi_nch_disp_if.slave  bus
);
  localparam int            CW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] RST_DATA = DW'(32'hAA5555AA);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] CH_LAST  = SW'(CH - 1);

  logic [DW-1:0] data_r [CH];
  logic [PW-1:0] pt_r   [CH];
  logic [PW-1:0] le_r   [CH];

  logic [CW-1:0] div_r;
  logic [SW-1:0] ch_out_r;
  logic [DW-1:0] disp_num_r;
  logic [PW-1:0] point_out_r;
  logic [PW-1:0] le_out_r;
  logic          ch_tick_r;

  logic [SW-1:0] ch_next_s;
  logic          adv_s;

  // Next channel: manual select (out-of-range falls back to 0) or auto scan.
  always_comb begin
    ch_next_s = ch_out_r;
    adv_s     = 1'b0;
    if (bus.mode == 1'b0) begin
      if (int'(bus.sel) < CH) begin
        ch_next_s = bus.sel;
      end else begin
        ch_next_s = {SW{1'b0}};
      end
    end else if (bus.freeze == 1'b1) begin
      ch_next_s = ch_out_r;
    end else if (div_r == DIV_LAST) begin
      adv_s = 1'b1;
      if (ch_out_r == CH_LAST) begin
        ch_next_s = {SW{1'b0}};
      end else begin
        ch_next_s = ch_out_r + SW'(1);
      end
    end else begin
      ch_next_s = ch_out_r;
    end
  end

  // Per-channel shadow registers; every strobed channel loads independently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) begin
        data_r[i] <= (i == 0) ? RST_DATA : {DW{1'b0}};
        pt_r[i]   <= {PW{1'b0}};
        le_r[i]   <= (i == 0) ? {PW{1'b1}} : {PW{1'b0}};
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (bus.load[i]) begin
          data_r[i] <= bus.data_in[i*DW +: DW];
          pt_r[i]   <= bus.point_in[i*PW +: PW];
          le_r[i]   <= bus.les_in[i*PW +: PW];
        end else begin
          data_r[i] <= data_r[i];
          pt_r[i]   <= pt_r[i];
          le_r[i]   <= le_r[i];
        end
      end
    end
  end

  // Scan divider: runs only in unfrozen auto mode, cleared in manual mode so
  // a switch to auto always starts a full dwell.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_r <= {CW{1'b0}};
    end else if (bus.mode == 1'b0) begin
      div_r <= {CW{1'b0}};
    end else if (bus.freeze == 1'b1) begin
      div_r <= div_r;
    end else if (div_r == DIV_LAST) begin
      div_r <= {CW{1'b0}};
    end else begin
      div_r <= div_r + CW'(1);
    end
  end

  // Registered output stage: channel index and its pre-load shadow contents
  // are captured on the same edge so they can never be skewed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_out_r    <= {SW{1'b0}};
      disp_num_r  <= RST_DATA;
      point_out_r <= {PW{1'b0}};
      le_out_r    <= {PW{1'b1}};
      ch_tick_r   <= 1'b0;
    end else begin
      ch_out_r    <= ch_next_s;
      disp_num_r  <= data_r[ch_next_s];
      point_out_r <= pt_r[ch_next_s];
      le_out_r    <= le_r[ch_next_s];
      ch_tick_r   <= adv_s;
    end
  end

  assign bus.disp_num  = disp_num_r;
  assign bus.point_out = point_out_r;
  assign bus.le_out    = le_out_r;
  assign bus.ch_out    = ch_out_r;
  assign bus.ch_tick   = ch_tick_r;
endmodule
